// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding load/store responder with fixed latency
// Accepts one request, waits LAT cycles, then holds the response until it is consumed.
module mem_responder #(
  parameter int WIDTH     = 16,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int LAT       = 2,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [WIDTH-1:0]  req_count
);

  localparam int CW = (LAT > 2) ? $clog2(LAT) : 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  generate
    if (LAT < 1) begin : g_bad_lat
      $error("mem_responder: LAT must be >= 1");
    end
    if (DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
      $error("mem_responder: DEPTH exceeds address space");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [WIDTH-1:0]  rdata_q;
  logic              err_q;
  logic              accept;
  logic              enter_resp;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_load;

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_V;
  endfunction

  always_comb begin
    state_n    = state;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LAT == 1) begin
            state_n    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_n    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // With LAT=1 the response is formed on the accepting edge, before addr_q is valid.
  assign rd_addr = (state == IDLE) ? req_addr : addr_q;
  assign rd_load = (state == IDLE) ? ~req_we : ~we_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      req_count <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q    <= req_addr;
        we_q      <= req_we;
        req_count <= req_count + 1'b1;
        if (LAT > 1) cnt <= CW'(LAT - 2);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (enter_resp) begin
        rdata_q <= (rd_load && in_range(rd_addr)) ? mem[rd_addr[IW-1:0]] : '0;
        err_q   <= ~in_range(rd_addr);
      end else if (state == RESP && rsp_ready) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  // Memory is deliberately outside the reset domain so stores survive rst.
  always_ff @(posedge clk) begin
    if (accept && !rst && req_we && in_range(req_addr))
      mem[req_addr[IW-1:0]] <= req_wdata;
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder
// Instance 0 runs LAT=2, instance 1 runs LAT=1; both have DEPTH=200.
module tb_mem_responder;

  localparam int W  = 16;
  localparam int AW = 8;
  localparam int D  = 200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req_valid [2];
  logic          req_ready [2];
  logic          req_we    [2];
  logic [AW-1:0] req_addr  [2];
  logic [W-1:0]  req_wdata [2];
  logic          rsp_valid [2];
  logic          rsp_ready [2];
  logic [W-1:0]  rsp_rdata [2];
  logic          rsp_err   [2];
  logic          busy      [2];
  logic [W-1:0]  req_count [2];

  mem_responder #(.WIDTH(W), .ADDR_W(AW), .DEPTH(D), .LAT(2), .INIT_FILE("")) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0]), .req_count(req_count[0])
  );

  mem_responder #(.WIDTH(W), .ADDR_W(AW), .DEPTH(D), .LAT(1), .INIT_FILE("")) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1]), .req_count(req_count[1])
  );

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] mmem [2][256];
  bit           mwr  [2][256];
  int           exp_cnt [2];

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic xact(input int i, input bit we, input logic [AW-1:0] a,
                      input logic [W-1:0] d, input int hold);
    int k;
    bit inr;
    bit known;
    logic [W-1:0] rd_exp;
    @(negedge clk);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i]  = a;
    req_wdata[i] = d;
    k = 0;
    while (!req_ready[i] && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("accept_ready", 32'(req_ready[i]), 32'd1);
    @(negedge clk);
    req_valid[i] = 1'b0;
    inr = (int'(a) < D);
    exp_cnt[i]++;
    known = we || !inr || mwr[i][a];
    rd_exp = (!we && inr) ? mmem[i][a] : '0;
    if (we && inr) begin
      mmem[i][a] = d;
      mwr[i][a]  = 1'b1;
    end
    k = 1;
    while (!rsp_valid[i] && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("latency", 32'(k), 32'(lat_of(i)));
    check("rsp_err", 32'(rsp_err[i]), 32'(!inr));
    if (known) check("rsp_rdata", 32'(rsp_rdata[i]), 32'(rd_exp));
    check("req_count", 32'(req_count[i]), 32'(exp_cnt[i] % 65536));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid[i]), 32'd1);
      check("hold_ready", 32'(req_ready[i]), 32'd0);
      check("hold_err", 32'(rsp_err[i]), 32'(!inr));
      if (known) check("hold_rdata", 32'(rsp_rdata[i]), 32'(rd_exp));
    end
    rsp_ready[i] = 1'b1;
    @(negedge clk);
    rsp_ready[i] = 1'b0;
    check("post_valid", 32'(rsp_valid[i]), 32'd0);
    check("post_ready", 32'(req_ready[i]), 32'd1);
    check("post_rdata", 32'(rsp_rdata[i]), 32'd0);
  endtask

  initial begin
    int acc;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
      rsp_ready[i] = 1'b0;
      exp_cnt[i]   = 0;
      for (int a = 0; a < 256; a++) mwr[i][a] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_req_ready", 32'(req_ready[i]), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
      check("rst_rsp_rdata", 32'(rsp_rdata[i]), 32'd0);
      check("rst_rsp_err", 32'(rsp_err[i]), 32'd0);
      check("rst_busy", 32'(busy[i]), 32'd0);
      check("rst_req_count", 32'(req_count[i]), 32'd0);
    end
    rst = 1'b0;

    xact(0, 1'b1, 8'd5, 16'h00AB, 0);
    xact(0, 1'b0, 8'd5, 16'h0000, 5);
    xact(0, 1'b0, 8'd250, 16'h0000, 0);
    xact(0, 1'b1, 8'd250, 16'h1234, 0);
    xact(0, 1'b0, 8'd250, 16'h0000, 2);
    xact(1, 1'b1, 8'd0, 16'h5A5A, 0);
    xact(1, 1'b0, 8'd0, 16'h0000, 0);
    xact(1, 1'b0, 8'd199, 16'h0000, 0);
    xact(1, 1'b1, 8'd200, 16'hFFFF, 0);

    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    req_addr[0]  = 8'd5;
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("mid_busy", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(rsp_valid[0]), 32'd0);
    check("mid_rst_ready", 32'(req_ready[0]), 32'd1);
    check("mid_rst_count", 32'(req_count[0]), 32'd0);
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("no_stale_rsp", 32'(rsp_valid[0]), 32'd0);
    end
    xact(0, 1'b0, 8'd5, 16'h0000, 0);

    @(negedge clk);
    acc = 0;
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b0;
    req_addr[1]  = 8'd0;
    rsp_ready[1] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (req_ready[1]) acc++;
      check("b2b_overlap", 32'(rsp_valid[1] && req_ready[1]), 32'd0);
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    rsp_ready[1] = 1'b0;
    exp_cnt[1] += 10;
    check("b2b_accepts", 32'(acc), 32'd10);
    check("b2b_count", 32'(req_count[1]), 32'(exp_cnt[1]));

    for (int n = 0; n < 60; n++) begin
      int i;
      logic [AW-1:0] a;
      i = int'($urandom_range(0, 1));
      a = ($urandom_range(0, 4) == 0) ? AW'($urandom_range(190, 255)) : AW'($urandom_range(0, 15));
      xact(i, 1'($urandom_range(0, 1)), a, W'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
